// File: rtl/riscv_ctrl_axil_regbank.sv
// riscv_ctrl_axil_regbank: AXI4-Lite control/status register bank for the RISC-V core wrapper.
// Provides run/reset control, cycle budget, sticky status, a cycle counter, an auto-incrementing
// instruction-memory load port and N generic user registers.
// Optional feature macro: RISCV_CTRL_IRQ_EN (IRQ_EN register at 0x18 plus a registered done interrupt).
module riscv_ctrl_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int N_USER_REGS        = 2,
  parameter int IMEM_ADDR_WIDTH    = 12
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            i_idle,
  input  logic                            i_running,
  input  logic                            i_done,
  output logic                            o_run,
  output logic                            o_mem_reset_n,
  output logic [31:0]                     o_num_cycle,
  output logic                            o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0]      o_imem_addr,
  output logic [31:0]                     o_imem_wdata,
  output logic [3:0]                      o_imem_wstrb,
  output logic [32*N_USER_REGS-1:0]       o_user,
  output logic                            o_irq
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Word indices (byte address / 4)
  localparam logic [31:0] W_STATUS    = 32'd0;
  localparam logic [31:0] W_NUM_CYCLE = 32'd1;
  localparam logic [31:0] W_CTRL      = 32'd2;
  localparam logic [31:0] W_CYCLE_CNT = 32'd3;
  localparam logic [31:0] W_IMEM_ADDR = 32'd4;
  localparam logic [31:0] W_IMEM_DATA = 32'd5;
  localparam logic [31:0] W_IRQ_EN    = 32'd6;
  localparam logic [31:0] W_RSVD      = 32'd7;
  localparam logic [31:0] W_USER      = 32'd8;
  localparam logic [31:0] W_END       = W_USER + 32'(N_USER_REGS);

  // Merge new bytes into an old word under a byte strobe
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic        wr_hs, rd_hs, w1c;
  logic [31:0] wr_word, rd_word;

  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          rvalid_q, rvalid_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic [31:0]                   num_cycle_q, num_cycle_d;
  logic                          mem_reset_q, mem_reset_d;
  logic                          run_q, run_d;
  logic [31:0]                   cycle_cnt_q, cycle_cnt_d;
  logic                          done_sticky_q, done_sticky_d;
  logic [IMEM_ADDR_WIDTH-1:0]    imem_addr_q, imem_addr_d;
  logic [IMEM_ADDR_WIDTH-1:0]    imem_waddr_q, imem_waddr_d;
  logic [31:0]                   imem_wdata_q, imem_wdata_d;
  logic [3:0]                    imem_wstrb_q, imem_wstrb_d;
  logic                          imem_we_q, imem_we_d;
  logic [32*N_USER_REGS-1:0]     user_q, user_d;
`ifdef RISCV_CTRL_IRQ_EN
  logic                          irq_en_q, irq_en_d;
  logic                          irq_q, irq_d;
`endif

  // Protection bits and byte offset within a word carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_hs   = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
  assign rd_hs   = S_AXI_ARVALID & ~rvalid_q;
  assign wr_word = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign rd_word = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);

  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rd_hs;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign o_run         = run_q;
  assign o_mem_reset_n = mem_reset_q;
  assign o_num_cycle   = num_cycle_q;
  assign o_imem_we     = imem_we_q;
  assign o_imem_addr   = imem_waddr_q;
  assign o_imem_wdata  = imem_wdata_q;
  assign o_imem_wstrb  = imem_wstrb_q;
  assign o_user        = user_q;
`ifdef RISCV_CTRL_IRQ_EN
  assign o_irq         = irq_q;
`else
  assign o_irq         = 1'b0;
`endif

  // Write channel: decode the accepted write and compute every register's next value
  always_comb begin
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    num_cycle_d   = num_cycle_q;
    mem_reset_d   = mem_reset_q;
    run_d         = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_waddr_d  = imem_waddr_q;
    imem_wdata_d  = imem_wdata_q;
    imem_wstrb_d  = imem_wstrb_q;
    imem_we_d     = 1'b0;
    user_d        = user_q;
    w1c           = 1'b0;
`ifdef RISCV_CTRL_IRQ_EN
    irq_en_d      = irq_en_q;
`endif
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (wr_word)
        W_STATUS:    w1c = S_AXI_WSTRB[0] & S_AXI_WDATA[2];
        W_NUM_CYCLE: num_cycle_d = apply_strb(num_cycle_q, S_AXI_WDATA, S_AXI_WSTRB);
        W_CTRL: begin
          if (S_AXI_WSTRB[0]) begin
            run_d       = S_AXI_WDATA[0];
            mem_reset_d = S_AXI_WDATA[1];
          end
        end
        W_CYCLE_CNT: ;
        W_IMEM_ADDR: begin
          for (int i = 2; i < IMEM_ADDR_WIDTH; i++) begin
            if (S_AXI_WSTRB[i/8]) imem_addr_d[i] = S_AXI_WDATA[i];
          end
        end
        W_IMEM_DATA: begin
          imem_wdata_d = S_AXI_WDATA;
          imem_wstrb_d = S_AXI_WSTRB;
          imem_waddr_d = imem_addr_q;
          imem_we_d    = 1'b1;
          imem_addr_d  = imem_addr_q + IMEM_ADDR_WIDTH'(4);
        end
        W_IRQ_EN: begin
`ifdef RISCV_CTRL_IRQ_EN
          if (S_AXI_WSTRB[0]) irq_en_d = S_AXI_WDATA[0];
`endif
        end
        W_RSVD: ;
        default: begin
          if (wr_word >= W_END) begin
            bresp_d = RESP_SLVERR;
          end else begin
            for (int k = 0; k < N_USER_REGS; k++) begin
              if (wr_word == W_USER + 32'(k))
                user_d[32*k +: 32] = apply_strb(user_q[32*k +: 32], S_AXI_WDATA, S_AXI_WSTRB);
            end
          end
        end
      endcase
    end
  end

  // Status side: sticky done (set beats clear), saturating cycle counter and optional interrupt
  always_comb begin
    done_sticky_d = done_sticky_q;
    if (run_q || w1c) done_sticky_d = 1'b0;
    if (i_done)       done_sticky_d = 1'b1;
    cycle_cnt_d = cycle_cnt_q;
    if (run_q)                                            cycle_cnt_d = 32'd0;
    else if (i_running && cycle_cnt_q != 32'hFFFF_FFFF)   cycle_cnt_d = cycle_cnt_q + 32'd1;
`ifdef RISCV_CTRL_IRQ_EN
    irq_d = done_sticky_q & irq_en_q;
`endif
  end

  // Read channel: capture read data on the address handshake and hold it until RREADY
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = 32'd0;
      case (rd_word)
        W_STATUS:    rdata_d = {29'd0, done_sticky_q, i_running, i_idle};
        W_NUM_CYCLE: rdata_d = num_cycle_q;
        W_CTRL:      rdata_d = {30'd0, mem_reset_q, 1'b0};
        W_CYCLE_CNT: rdata_d = cycle_cnt_q;
        W_IMEM_ADDR: rdata_d = 32'(imem_addr_q);
        W_IMEM_DATA: rdata_d = imem_wdata_q;
        W_IRQ_EN: begin
`ifdef RISCV_CTRL_IRQ_EN
          rdata_d = {31'd0, irq_en_q};
`endif
        end
        W_RSVD: ;
        default: begin
          if (rd_word >= W_END) begin
            rresp_d = RESP_SLVERR;
          end else begin
            for (int k = 0; k < N_USER_REGS; k++) begin
              if (rd_word == W_USER + 32'(k)) rdata_d = user_q[32*k +: 32];
            end
          end
        end
      endcase
    end
  end

  // State register: everything clears on reset, which also holds the core memory in reset
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      rvalid_q      <= 1'b0;
      rresp_q       <= 2'b00;
      rdata_q       <= 32'd0;
      num_cycle_q   <= 32'd0;
      mem_reset_q   <= 1'b0;
      run_q         <= 1'b0;
      cycle_cnt_q   <= 32'd0;
      done_sticky_q <= 1'b0;
      imem_addr_q   <= '0;
      imem_waddr_q  <= '0;
      imem_wdata_q  <= 32'd0;
      imem_wstrb_q  <= 4'd0;
      imem_we_q     <= 1'b0;
      user_q        <= '0;
`ifdef RISCV_CTRL_IRQ_EN
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
`endif
    end else begin
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      num_cycle_q   <= num_cycle_d;
      mem_reset_q   <= mem_reset_d;
      run_q         <= run_d;
      cycle_cnt_q   <= cycle_cnt_d;
      done_sticky_q <= done_sticky_d;
      imem_addr_q   <= imem_addr_d;
      imem_waddr_q  <= imem_waddr_d;
      imem_wdata_q  <= imem_wdata_d;
      imem_wstrb_q  <= imem_wstrb_d;
      imem_we_q     <= imem_we_d;
      user_q        <= user_d;
`ifdef RISCV_CTRL_IRQ_EN
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_riscv_ctrl_axil_regbank.sv
// tb_riscv_ctrl_axil_regbank: scoreboard bench for the RISC-V control register bank.
// Stimulus pushes expected AXI responses and IMEM writes into queues; a monitor pops and compares.
// Covers both builds of the RISCV_CTRL_IRQ_EN option.
module tb_riscv_ctrl_axil_regbank;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [1:0]  resp;
  } axi_exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } imem_exp_t;

  logic        clk, rst;
  logic [7:0]  s_awaddr, s_araddr;
  logic [2:0]  s_awprot, s_arprot;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic        i_idle, i_running, i_done;
  logic        o_run, o_mem_reset_n, o_imem_we, o_irq;
  logic [31:0] o_num_cycle, o_imem_wdata;
  logic [11:0] o_imem_addr;
  logic [3:0]  o_imem_wstrb;
  logic [63:0] o_user;

  axi_exp_t  wr_q[$];
  axi_exp_t  rd_q[$];
  imem_exp_t imem_q[$];
  int        checks = 0;
  int        errors = 0;
  int        run_pulses = 0;

  riscv_ctrl_axil_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(8),
    .N_USER_REGS(2),
    .IMEM_ADDR_WIDTH(12)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(s_awaddr), .S_AXI_AWPROT(s_awprot), .S_AXI_AWVALID(s_awvalid), .S_AXI_AWREADY(s_awready),
    .S_AXI_WDATA(s_wdata), .S_AXI_WSTRB(s_wstrb), .S_AXI_WVALID(s_wvalid), .S_AXI_WREADY(s_wready),
    .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready),
    .S_AXI_ARADDR(s_araddr), .S_AXI_ARPROT(s_arprot), .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
    .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready),
    .i_idle(i_idle), .i_running(i_running), .i_done(i_done),
    .o_run(o_run), .o_mem_reset_n(o_mem_reset_n), .o_num_cycle(o_num_cycle),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_imem_wstrb(o_imem_wstrb), .o_user(o_user), .o_irq(o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout/unexpected event expected handshake", name);
  endtask

  task automatic apply_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input bit with_done);
    axi_exp_t e;
    int n;
    e.name = $sformatf("write_%02h", addr);
    e.data = 32'd0;
    e.resp = exp_resp;
    wr_q.push_back(e);
    @(posedge clk); #1;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    if (with_done) i_done = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(s_awready && s_wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now({e.name, "_aw_timeout"});
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (with_done) i_done = 1'b0;
  endtask

  task automatic apply_read(input logic [7:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    axi_exp_t e;
    int n;
    e.name = $sformatf("read_%02h", addr);
    e.data = exp_data;
    e.resp = exp_resp;
    rd_q.push_back(e);
    @(posedge clk); #1;
    s_araddr = addr;
    s_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now({e.name, "_ar_timeout"});
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic push_imem(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    imem_exp_t m;
    m.addr = addr; m.data = data; m.strb = strb;
    imem_q.push_back(m);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    i_done = 1'b1;
    @(posedge clk); #1;
    i_done = 1'b0;
  endtask

  // Monitor: compare every response / IMEM write the DUT presents against the scoreboard queues
  initial begin : monitor
    axi_exp_t  e;
    imem_exp_t m;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s_bvalid && s_bready) begin
          if (wr_q.size() == 0) fail_now("unexpected_bvalid");
          else begin
            e = wr_q.pop_front();
            check_output({e.name, "_bresp"}, 32'(s_bresp), 32'(e.resp));
          end
        end
        if (s_rvalid && s_rready) begin
          if (rd_q.size() == 0) fail_now("unexpected_rvalid");
          else begin
            e = rd_q.pop_front();
            check_output({e.name, "_rdata"}, s_rdata, e.data);
            check_output({e.name, "_rresp"}, 32'(s_rresp), 32'(e.resp));
          end
        end
        if (o_imem_we) begin
          if (imem_q.size() == 0) fail_now("unexpected_imem_we");
          else begin
            m = imem_q.pop_front();
            check_output("imem_addr", 32'(o_imem_addr), 32'(m.addr));
            check_output("imem_wdata", o_imem_wdata, m.data);
            check_output("imem_wstrb", 32'(o_imem_wstrb), 32'(m.strb));
          end
        end
        if (o_run) run_pulses++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    s_awaddr = '0; s_araddr = '0; s_awprot = '0; s_arprot = '0;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
    i_idle = 1'b1; i_running = 1'b0; i_done = 1'b0;

    repeat (3) @(negedge clk);
    check_output("rst_mem_reset_n", 32'(o_mem_reset_n), 32'd0);
    check_output("rst_bvalid", 32'(s_bvalid), 32'd0);
    check_output("rst_rvalid", 32'(s_rvalid), 32'd0);
    check_output("rst_run", 32'(o_run), 32'd0);
    rst = 1'b0;

    // Reset state through the bus
    apply_read(8'h00, 32'h1, 2'b00);
    apply_read(8'h08, 32'h0, 2'b00);
    @(negedge clk);
    check_output("mem_reset_n_after_rst", 32'(o_mem_reset_n), 32'd0);

    // Count 5 running cycles, then CTRL=3 pulses run, clears the counter, releases memory reset
    i_running = 1'b1;
    repeat (5) @(posedge clk);
    #1 i_running = 1'b0;
    apply_read(8'h0C, 32'd5, 2'b00);
    apply_write(8'h08, 32'h3, 4'hF, 2'b00, 1'b0);
    @(negedge clk);
    check_output("mem_reset_n_set", 32'(o_mem_reset_n), 32'd1);
    check_output("run_one_pulse", 32'(run_pulses), 32'd1);
    apply_read(8'h08, 32'h2, 2'b00);
    apply_read(8'h0C, 32'd0, 2'b00);
    @(posedge clk); #1 i_running = 1'b1;
    repeat (10) @(posedge clk);
    #1 i_running = 1'b0;
    apply_read(8'h0C, 32'd10, 2'b00);

    // NUM_CYCLE with byte masking
    apply_write(8'h04, 32'h12345678, 4'hF, 2'b00, 1'b0);
    apply_write(8'h04, 32'hAABBCCDD, 4'b0101, 2'b00, 1'b0);
    apply_read(8'h04, 32'h12BB56DD, 2'b00);
    @(negedge clk);
    check_output("o_num_cycle", o_num_cycle, 32'h12BB56DD);

    // IMEM load with wrap at the top of the 12-bit space
    apply_write(8'h10, 32'h00000FFC, 4'hF, 2'b00, 1'b0);
    apply_read(8'h10, 32'h00000FFC, 2'b00);
    push_imem(12'hFFC, 32'h00000013, 4'hF);
    apply_write(8'h14, 32'h00000013, 4'hF, 2'b00, 1'b0);
    push_imem(12'h000, 32'h00100093, 4'hF);
    apply_write(8'h14, 32'h00100093, 4'hF, 2'b00, 1'b0);
    apply_read(8'h10, 32'h00000004, 2'b00);
    apply_read(8'h14, 32'h00100093, 2'b00);
    apply_write(8'h10, 32'h00000012, 4'hF, 2'b00, 1'b0);
    apply_read(8'h10, 32'h00000010, 2'b00);

    // Sticky done: set wins over a simultaneous W1C, second W1C clears, run pulse clears
    pulse_done();
    apply_read(8'h00, 32'h5, 2'b00);
    apply_write(8'h00, 32'h4, 4'h1, 2'b00, 1'b1);
    apply_read(8'h00, 32'h5, 2'b00);
    apply_write(8'h00, 32'h4, 4'h1, 2'b00, 1'b0);
    apply_read(8'h00, 32'h1, 2'b00);
    pulse_done();
    apply_write(8'h08, 32'h3, 4'hF, 2'b00, 1'b0);
    apply_read(8'h00, 32'h1, 2'b00);

    // Reserved word
    apply_write(8'h1C, 32'hFFFFFFFF, 4'hF, 2'b00, 1'b0);
    apply_read(8'h1C, 32'h0, 2'b00);

    // User registers and out-of-range decode
    apply_write(8'h20, 32'hDEADBEEF, 4'hF, 2'b00, 1'b0);
    apply_write(8'h24, 32'hAABBCCDD, 4'b0010, 2'b00, 1'b0);
    apply_read(8'h24, 32'h0000CC00, 2'b00);
    apply_read(8'h23, 32'hDEADBEEF, 2'b00);
    apply_read(8'h28, 32'h0, 2'b10);
    apply_read(8'hFC, 32'h0, 2'b10);
    apply_write(8'h28, 32'h11111111, 4'hF, 2'b10, 1'b0);
    apply_read(8'h20, 32'hDEADBEEF, 2'b00);
    apply_read(8'h24, 32'h0000CC00, 2'b00);
    @(negedge clk);
    check_output("o_user0", o_user[31:0], 32'hDEADBEEF);
    check_output("o_user1", o_user[63:32], 32'h0000CC00);

`ifdef RISCV_CTRL_IRQ_EN
    // Interrupt: rises one cycle after done_sticky, drops after W1C
    apply_write(8'h18, 32'h1, 4'h1, 2'b00, 1'b0);
    apply_read(8'h18, 32'h1, 2'b00);
    @(negedge clk);
    check_output("irq_idle", 32'(o_irq), 32'd0);
    pulse_done();
    @(negedge clk);
    check_output("irq_latency_low", 32'(o_irq), 32'd0);
    @(negedge clk);
    check_output("irq_asserted", 32'(o_irq), 32'd1);
    apply_write(8'h00, 32'h4, 4'h1, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    check_output("irq_cleared", 32'(o_irq), 32'd0);
`else
    // Without the interrupt option 0x18 is reserved and o_irq never rises
    apply_write(8'h18, 32'h1, 4'h1, 2'b00, 1'b0);
    apply_read(8'h18, 32'h0, 2'b00);
    pulse_done();
    repeat (3) @(negedge clk);
    check_output("irq_tied_low", 32'(o_irq), 32'd0);
    apply_write(8'h00, 32'h4, 4'h1, 2'b00, 1'b0);
`endif

    // Reset in the middle of a write and a read: valids drop, no run pulse is seen
    @(posedge clk); #1;
    s_awaddr = 8'h08; s_wdata = 32'h1; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 8'h00; s_arvalid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(negedge clk);
    check_output("midrst_bvalid", 32'(s_bvalid), 32'd0);
    check_output("midrst_rvalid", 32'(s_rvalid), 32'd0);
    check_output("midrst_mem_reset_n", 32'(o_mem_reset_n), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_output("run_pulse_total", 32'(run_pulses), 32'd2);
    apply_read(8'h08, 32'h0, 2'b00);
    apply_read(8'h04, 32'h0, 2'b00);
    apply_read(8'h10, 32'h0, 2'b00);
    apply_read(8'h20, 32'h0, 2'b00);
    apply_read(8'h00, 32'h1, 2'b00);

    repeat (4) @(negedge clk);
    check_output("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check_output("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check_output("imem_queue_drained", 32'(imem_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_ctrl_axil_regbank.md
# riscv_ctrl_axil_regbank

Parametrised AXI4-Lite slave register bank sitting between the PS interconnect and the RISC-V core wrapper. It provides core control (run pulse, memory reset, cycle budget), sticky status, a hardware cycle counter, and an auto-incrementing instruction-memory load port. It also adds N generic user registers, SLVERR on unmapped addresses, and an optional done interrupt.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 8: byte address width; must cover 0x20 + 4*N_USER_REGS.
- N_USER_REGS, 2: generic RW registers, range 0..56.
- IMEM_ADDR_WIDTH, 12: byte address width of the instruction port.
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave channels, standard widths; AWPROT and ARPROT are ignored.
- i_idle, i_running  in  1  core status levels.
- i_done  in  1  single-cycle completion tick.
- o_run  out  1  single-cycle start pulse.
- o_mem_reset_n  out  1  core memory reset level.
- o_num_cycle  out  32  cycle budget.
- o_imem_we  out  1  instruction write pulse.
- o_imem_addr  out  IMEM_ADDR_WIDTH  instruction byte address.
- o_imem_wdata  out  32  instruction word.
- o_imem_wstrb  out  4  byte strobes for the instruction write.
- o_user  out  32*N_USER_REGS  user registers, concatenated; reg k occupies bits [32k+31:32k].
- o_irq  out  1  level interrupt.

## Operation
- Address decode uses addr[C_S_AXI_ADDR_WIDTH-1:2]; addr[1:0] is ignored.
- 0x00 STATUS (RO, except bit2):
  - bit0 = i_idle, bit1 = i_running, bit2 = done_sticky.
  - Writing 1 to bit2 (with WSTRB[0] set) clears done_sticky.
- 0x04 NUM_CYCLE (RW): drives o_num_cycle; byte-masked by WSTRB.
- 0x08 CTRL:
  - bit0 is write-1-to-pulse: o_run pulses for one cycle and bit0 always reads 0.
  - bit1 is a RW level driving o_mem_reset_n.
  - Bits act only when WSTRB[0] is set.
- 0x0C CYCLE_CNT (RO):
  - Increments each cycle i_running is high.
  - Clears to 0 on an o_run pulse.
  - Saturates at 0xFFFF_FFFF.
- 0x10 IMEM_ADDR (RW): the next load address; bits [1:0] are forced to 0.
- 0x14 IMEM_DATA (WO):
  - A write latches o_imem_wdata/o_imem_wstrb from WDATA/WSTRB and asserts o_imem_we for one cycle with the current IMEM_ADDR.
  - IMEM_ADDR then advances by 4, wrapping modulo 2^IMEM_ADDR_WIDTH.
  - A read returns the last word written.
- 0x18 IRQ_EN (RW bit0): present only with the macro (see Configuration).
- 0x1C: reserved; reads 0, writes ignored, OKAY response.
- 0x20 + 4k, k < N_USER_REGS: user register k, RW, byte-masked.
- Any address ≥ 0x20 + 4*N_USER_REGS returns SLVERR (2'b10); read data is 0 and the write is discarded.
- done_sticky:
  - Set by i_done; cleared by an o_run pulse or a W1C write.
  - If set and clear occur in the same cycle, set wins.
- Read and write channels are independent. A read of a register written in the same cycle returns the pre-write value.

## Timing
- All outputs and registers are 0 during reset, except o_mem_reset_n = 0 (memory held in reset) and IMEM_ADDR = 0.
- Write handshake:
  - AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
  - Register update, o_run and o_imem_we all occur on the edge that ends that cycle, so the pulses are visible the cycle after the handshake.
  - BVALID asserts on the same edge and holds until BREADY.
  - No new write is accepted while BVALID is high.
- Read handshake:
  - ARREADY pulses for one cycle when ARVALID & !RVALID.
  - RDATA/RRESP are registered; RVALID asserts the next cycle and holds, stable, until RREADY.
- CYCLE_CNT reflects i_running with one cycle of latency.
- Asserting reset mid-transaction drops BVALID and RVALID immediately; no pulse is issued.

## Configuration
- RISCV_CTRL_IRQ_EN defined:
  - IRQ_EN at 0x18 is implemented.
  - o_irq is registered done_sticky & IRQ_EN[0], asserting one cycle after done_sticky sets.
  - It clears via W1C on STATUS or an o_run pulse.
- RISCV_CTRL_IRQ_EN undefined:
  - 0x18 behaves as reserved (reads 0, OKAY).
  - o_irq is tied to 0.

## Test plan
- Reset release: read STATUS with i_idle=1 → 0x1, OKAY; read CTRL → 0x0; o_mem_reset_n = 0.
- Write CTRL = 0x3:
  - o_run high for exactly one cycle.
  - o_mem_reset_n = 1.
  - CTRL reads 0x2.
  - CYCLE_CNT clears, then reads 10 after 10 cycles of i_running.
- IMEM load: write IMEM_ADDR = 0xFFC (IMEM_ADDR_WIDTH=12), then IMEM_DATA = 0x00000013 and 0x00100093 → we pulses at 0xFFC then 0x000; IMEM_ADDR reads 0x004.
- Sticky done: pulse i_done → STATUS bit2 = 1. Write STATUS 0x4 in the same cycle as a second i_done → bit2 stays 1; a second W1C clears it.
- Out of range (N_USER_REGS=2): read 0x28 → RRESP = 2'b10, RDATA = 0. Write 0x28 → BRESP = 2'b10 and no register changes. Write 0x24 with WSTRB = 4'b0010, WDATA = 0xAABBCCDD → user reg 1 = 0x0000CC00.
- With RISCV_CTRL_IRQ_EN: set IRQ_EN = 1, pulse i_done → o_irq rises 1 cycle after done_sticky sets; W1C drops it. Without the macro, o_irq stays 0 and 0x18 reads 0.
